// File: rtl/gpu_pkg.sv
// Shared definitions for the gpu point path: default geometry, point packing and
// plotter state encoding.
package gpu_pkg;

    localparam int unsigned XW_DEFAULT = 4;
    localparam int unsigned YW_DEFAULT = 4;
    localparam int unsigned CW_DEFAULT = 8;

    // Packed point layout {x, y} at the default geometry.
    localparam int unsigned PT_X_MSB = XW_DEFAULT + YW_DEFAULT - 1;
    localparam int unsigned PT_X_LSB = YW_DEFAULT;
    localparam int unsigned PT_Y_MSB = YW_DEFAULT - 1;
    localparam int unsigned PT_Y_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SCAN  = 2'd2
    } state_e;

endpackage

// File: rtl/fb_row_bank.sv
// One-bit framebuffer storage: single-pixel set, whole-row clear and a registered
// row read port.
module fb_row_bank #(
    parameter int unsigned XW = 4,
    parameter int unsigned YW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_we,
    input  logic [XW-1:0]     set_x,
    input  logic [YW-1:0]     set_y,
    input  logic              clr,
    input  logic [YW-1:0]     clr_row,
    input  logic              rd_en,
    input  logic [YW-1:0]     rd_row,
    output logic [2**XW-1:0]  rd_data
);

    localparam int unsigned W = 2 ** XW;
    localparam int unsigned H = 2 ** YW;

    logic [W-1:0] mem [H];

    for (genvar r = 0; r < H; r++) begin : g_row
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem[r] <= '0;
            end else if (clr && clr_row == YW'(r)) begin
                mem[r] <= '0;
            end else if (set_we && set_y == YW'(r)) begin
                mem[r][set_x] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_row];
        end
    end

endmodule

// File: rtl/fb_point_plotter.sv
// Point-stream consumer: plots {x,y} points into a 1-bit framebuffer and offers
// whole-frame clear and row-by-row scan-out.
module fb_point_plotter
    import gpu_pkg::*;
#(
    parameter int unsigned XW = XW_DEFAULT,
    parameter int unsigned YW = YW_DEFAULT,
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pt_valid,
    input  logic [XW+YW-1:0]  pt_data,
    output logic              pt_ready,
    input  logic              clr_req,
    input  logic              scan_req,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [YW-1:0]     row_idx,
    output logic [2**XW-1:0]  row_data,
    output logic              frame_done,
    output logic              busy,
    output logic [CW-1:0]     plot_cnt
);

    localparam logic [YW-1:0] LAST_ROW = {YW{1'b1}};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_e        state_q, state_d;
    logic [YW-1:0] row_q, row_d, row_inc, rd_row;
    logic          row_valid_q, row_valid_d;
    logic          frame_done_q, frame_done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pt_accept, clr_start, scan_start, row_take, last_row, rd_en;

    assign pt_accept  = pt_valid && pt_ready;
    assign clr_start  = (state_q == ST_IDLE) && clr_req;
    assign scan_start = (state_q == ST_IDLE) && scan_req && !clr_req;
    assign row_take   = (state_q == ST_SCAN) && row_valid_q && row_ready;
    assign last_row   = (row_q == LAST_ROW);
    assign row_inc    = row_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                end else if (scan_req) begin
                    state_d = ST_SCAN;
                end
            end
            ST_CLEAR: if (last_row) state_d = ST_IDLE;
            ST_SCAN:  if (row_take && last_row) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pt_ready = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
    end

    // Row counter is shared by clear and scan; it is reset to 0 whenever either ends.
    always_comb begin
        row_d        = row_q;
        row_valid_d  = row_valid_q;
        frame_done_d = 1'b0;
        cnt_d        = cnt_q;
        if (pt_accept && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (clr_start) begin
            cnt_d = '0;
            row_d = '0;
        end
        if (scan_start) begin
            row_d       = '0;
            row_valid_d = 1'b1;
        end
        if (state_q == ST_CLEAR) row_d = last_row ? '0 : row_inc;
        if (row_take) begin
            if (last_row) begin
                row_d        = '0;
                row_valid_d  = 1'b0;
                frame_done_d = 1'b1;
            end else begin
                row_d = row_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q        <= '0;
            row_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            row_q        <= row_d;
            row_valid_q  <= row_valid_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
        end
    end

    // Prefetch the next row on each accepted transfer so scan-out has no bubble.
    assign rd_en  = scan_start || (row_take && !last_row);
    assign rd_row = scan_start ? '0 : row_inc;

    fb_row_bank #(
        .XW (XW),
        .YW (YW)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_we  (pt_accept),
        .set_x   (pt_data[XW+YW-1:YW]),
        .set_y   (pt_data[YW-1:0]),
        .clr     (state_q == ST_CLEAR),
        .clr_row (row_q),
        .rd_en   (rd_en),
        .rd_row  (rd_row),
        .rd_data (row_data)
    );

    assign row_valid  = row_valid_q;
    assign row_idx    = row_q;
    assign frame_done = frame_done_q;
    assign plot_cnt   = cnt_q;

endmodule

// File: tb/tb_fb_point_plotter.sv
// Directed bench for fb_point_plotter with a small framebuffer/counter model.
module tb_fb_point_plotter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pt_valid = 1'b0;
    logic [7:0]  pt_data = '0;
    logic        pt_ready;
    logic        clr_req = 1'b0;
    logic        scan_req = 1'b0;
    logic        row_valid;
    logic        row_ready = 1'b0;
    logic [3:0]  row_idx;
    logic [15:0] row_data;
    logic        frame_done;
    logic        busy;
    logic [7:0]  plot_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_fb [16];
    int          model_cnt = 0;

    fb_point_plotter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pt_valid   (pt_valid),
        .pt_data    (pt_data),
        .pt_ready   (pt_ready),
        .clr_req    (clr_req),
        .scan_req   (scan_req),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_idx    (row_idx),
        .row_data   (row_data),
        .frame_done (frame_done),
        .busy       (busy),
        .plot_cnt   (plot_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 16; r++) model_fb[r] = '0;
        model_cnt = 0;
    endtask

    task automatic plot(input logic [7:0] p);
        pt_valid = 1'b1;
        pt_data  = p;
        tick();
        pt_valid = 1'b0;
        model_fb[p[3:0]][p[7:4]] = 1'b1;
        if (model_cnt < 255) model_cnt++;
    endtask

    // Scan one frame; optionally stall 3 cycles at stall_row while offering a stray point.
    task automatic scan_frame(input string tag, input int stall_row, input bit poke);
        int          n = 0;
        int          cyc = 0;
        bit          stalled = 0;
        logic [15:0] held_d;
        logic [3:0]  held_i;
        row_ready = 1'b1;
        scan_req  = 1'b1;
        tick();
        scan_req = 1'b0;
        if (poke) begin
            pt_valid = 1'b1;
            pt_data  = 8'hFF;
        end
        while (n < 16 && cyc < 100) begin
            if (row_valid && int'(row_idx) == stall_row && !stalled) begin
                held_d    = row_data;
                held_i    = row_idx;
                row_ready = 1'b0;
                repeat (3) begin
                    tick();
                    chk({tag, " stall idx"}, row_idx, held_i);
                    chk({tag, " stall data"}, row_data, held_d);
                    chk({tag, " stall valid"}, row_valid, 1);
                    chk({tag, " stall pt_ready"}, pt_ready, 0);
                end
                row_ready = 1'b1;
                stalled   = 1;
            end
            if (row_valid) begin
                chk({tag, " row order"}, row_idx, n);
                chk($sformatf("%s row %0d data", tag, n), row_data, model_fb[n]);
                chk({tag, " frame_done early"}, frame_done, 0);
                n++;
            end
            tick();
            cyc++;
        end
        pt_valid = 1'b0;
        chk({tag, " row transfers"}, n, 16);
        chk({tag, " frame_done pulse"}, frame_done, 1);
        chk({tag, " row_valid after last"}, row_valid, 0);
        tick();
        chk({tag, " frame_done one cycle"}, frame_done, 0);
        chk({tag, " idle after scan"}, busy, 0);
    endtask

    initial begin
        int n;
        model_clear();

        // Reset held with a point offered.
        pt_valid = 1'b1;
        pt_data  = 8'h35;
        repeat (3) tick();
        chk("rst pt_ready", pt_ready, 1);
        chk("rst row_valid", row_valid, 0);
        chk("rst row_idx", row_idx, 0);
        chk("rst row_data", row_data, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst busy", busy, 0);
        chk("rst plot_cnt", plot_cnt, 0);
        rst_n    = 1'b1;
        pt_valid = 1'b0;
        tick();
        chk("post-rst busy", busy, 0);
        chk("post-rst plot_cnt", plot_cnt, 0);
        scan_frame("rst scan", -1, 0);
        chk("rst scan plot_cnt", plot_cnt, 0);

        // Plot then scan.
        plot(8'h35);
        plot(8'h3A);
        plot(8'hF0);
        chk("plot cnt 3", plot_cnt, 3);
        chk("model row5", model_fb[5], 16'h0008);
        chk("model row0", model_fb[0], 16'h8000);
        scan_frame("plot scan", -1, 0);
        chk("plot scan cnt", plot_cnt, 3);

        // Back-pressure at row 4 with a point offered during the scan.
        scan_frame("bp scan", 4, 1);
        chk("bp cnt unchanged", plot_cnt, 3);

        // Clear has priority over scan; the same-cycle point is written then erased.
        pt_valid = 1'b1;
        pt_data  = 8'h77;
        clr_req  = 1'b1;
        scan_req = 1'b1;
        tick();
        pt_valid = 1'b0;
        clr_req  = 1'b0;
        scan_req = 1'b0;
        chk("clr cnt zero on entry", plot_cnt, 0);
        chk("clr pt_ready", pt_ready, 0);
        n = 0;
        while (busy && n < 40) begin
            chk("clr no row_valid", row_valid, 0);
            n++;
            tick();
        end
        chk("clr busy cycles", n, 16);
        model_clear();
        scan_frame("clr scan", -1, 0);
        chk("clr plot_cnt", plot_cnt, 0);

        // Saturation.
        for (int i = 0; i < 300; i++) plot(8'h11);
        chk("sat plot_cnt", plot_cnt, 255);
        chk("sat model cnt", plot_cnt, model_cnt);
        scan_frame("sat scan", -1, 0);

        // Reset mid-scan at row 7.
        row_ready = 1'b1;
        scan_req  = 1'b1;
        tick();
        scan_req = 1'b0;
        n = 0;
        while (!(row_valid && row_idx == 4'd7) && n < 50) begin
            tick();
            n++;
        end
        chk("mid-scan reached row7", row_idx, 7);
        rst_n = 1'b0;
        #1;
        chk("mid-rst row_valid", row_valid, 0);
        chk("mid-rst busy", busy, 0);
        chk("mid-rst pt_ready", pt_ready, 1);
        chk("mid-rst frame_done", frame_done, 0);
        chk("mid-rst plot_cnt", plot_cnt, 0);
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            tick();
            if (frame_done) n++;
        end
        chk("mid-rst no frame_done", n, 0);
        model_clear();
        scan_frame("mid-rst scan", -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_point_plotter.md
Name: fb_point_plotter

Overview:
- Consumer end of the rasterizer's point stream. Accepts packed 8-bit points {x[3:0], y[3:0]} over a valid/ready handshake and sets the matching pixel in a 16x16 one-bit framebuffer.
- Provides a whole-frame clear sequence and a row-by-row scan-out port toward display/readback logic.
- Sits between the triangle edge rasterizer and the display path in the gpu directory.

Parameters:
- XW, 4, x coordinate width; framebuffer width is 2**XW columns.
- YW, 4, y coordinate width; framebuffer height is 2**YW rows.
- CW, 8, width of the saturating plot counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- pt_valid  in  1  point available on pt_data.
- pt_data  in  XW+YW  packed point; x in the upper XW bits, y in the lower YW bits.
- pt_ready  out  1  plotter accepts a point this cycle.
- clr_req  in  1  one-cycle request to clear the whole frame.
- scan_req  in  1  one-cycle request to scan out the frame.
- row_valid  out  1  row_data/row_idx are valid.
- row_ready  in  1  downstream takes the current row.
- row_idx  out  YW  index of the row being presented.
- row_data  out  2**XW  row bitmap; bit x corresponds to column x.
- frame_done  out  1  one-cycle pulse after the last row is accepted.
- busy  out  1  state is not IDLE.
- plot_cnt  out  CW  accepted points since the last reset or clear; saturates at 2**CW-1.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All framebuffer bits 0; state IDLE; pt_ready=1; row_valid=0; row_idx=0; row_data=0; frame_done=0; busy=0; plot_cnt=0.
  - Reset asserted mid-CLEAR or mid-SCAN aborts the operation immediately; no frame_done is produced.
- States: IDLE, CLEAR, SCAN.
  - pt_ready = (state==IDLE). It depends only on state, never combinationally on inputs.
  - busy = (state!=IDLE).
- Plot (IDLE):
  - A point is accepted when pt_valid && pt_ready. On that edge, bit fb[y][x] is set; it is readable from the next cycle.
  - plot_cnt increments on every accepted point, including points that land on a pixel already set.
- Request priority in IDLE:
  - clr_req has priority over scan_req when both are high in the same cycle; the scan request is dropped.
  - A point accepted in the same cycle as clr_req is written and counted, then erased by the clear.
  - clr_req and scan_req are ignored outside IDLE.
- CLEAR:
  - Row counter starts at 0 and zeroes one row per cycle, rows 0..2**YW-1, taking 16 cycles at the defaults.
  - plot_cnt is set to 0 on entry.
  - After the last row is cleared, the next state is IDLE.
- SCAN:
  - Next cycle after entry: row_valid=1, row_idx=0, row_data=fb[0].
  - row_idx/row_data are registered and held stable while row_valid && !row_ready.
  - On row_valid && row_ready, advance to the next row; the following row is presented the next cycle with no bubble (1 row/cycle when row_ready stays high).
  - When the row with row_idx=2**YW-1 is accepted: row_valid=0 the next cycle, frame_done=1 for exactly one cycle, state returns to IDLE.
  - pt_valid during SCAN is back-pressured (pt_ready=0); the framebuffer is not modified during SCAN.
- Arithmetic and widths:
  - x and y are unsigned; every in-range value is legal, with no wrap beyond the field width.
  - plot_cnt saturates at 2**CW-1 and does not wrap.
  - row_idx wraps only by returning to IDLE, never by counter overflow.

Decomposition:
- Shared package gpu_pkg:
  - XW, YW, CW defaults.
  - Point field positions: PT_X_MSB, PT_X_LSB, PT_Y_MSB, PT_Y_LSB.
  - State encoding constants ST_IDLE, ST_CLEAR, ST_SCAN.
- One sub-module, fb_row_bank, holds the 2**YW x 2**XW storage:
  - Single-bit set port (x, y, we).
  - Whole-row clear port (row, clr).
  - Registered row read port.
  - The FSM, handshake and counters stay in fb_point_plotter.

Test Plan:
- Reset: hold rst_n=0 with pt_valid=1 and pt_data=8'h35, then release → all outputs at reset values; first scan returns all 16 rows = 16'h0000; plot_cnt=0.
- Plot then scan: send 8'h35, 8'h3A, 8'hF0, then pulse scan_req with row_ready=1 → row 5 = 16'h0008, row 10 = 16'h0008, row 0 = 16'h8000, all other rows 0; frame_done pulses one cycle after row 15; plot_cnt=3.
- Scan back-pressure: drop row_ready for 3 cycles while row_idx=4 → row_idx and row_data stay stable; pt_ready=0 throughout; exactly 16 row transfers; rows arrive in order 0..15.
- Clear priority: pulse clr_req and scan_req together while pt_valid=1 with 8'h77 → point accepted; busy=1 for 16 cycles; no row_valid; a following scan returns all zeros; plot_cnt=0.
- Saturation: plot 300 points (all pixel 8'h11) → plot_cnt=255; only row 1 = 16'h0002 is set.
- Reset mid-scan: assert rst_n=0 while row_idx=7 → row_valid=0 immediately; no frame_done; framebuffer zeroed; state IDLE.
